pc_fetch_ctrl: RTL and testbench

- Consumer of the 3-bit pcSource produced by the branch-condition generator. It owns the program counter and applies pcSource at each instruction commit.
- Fetches the next instruction over a single-outstanding req/ready/rvalid instruction-memory handshake, then holds it for decode until the core commits.
- Sits between the core's execute/writeback control and instruction memory.

---
 rtl/otter_pkg.sv | 24 ++
 rtl/pc_next_mux.sv | 26 ++
 rtl/pc_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared types and constants for the PC/fetch control slice.
package otter_pkg;

   typedef enum logic [2:0] {
      PC_PLUS4  = 3'd0,
      PC_JALR   = 3'd1,
      PC_BRANCH = 3'd2,
      PC_JAL    = 3'd3
   } pc_src_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection from pcSource; reserved encodings fall back to pc+4.
module pc_next_mux
   import otter_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [2:0]  pc_source,
   input  logic [31:0] jalr_target,
   input  logic [31:0] branch_target,
   input  logic [31:0] jal_target,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   // Select the candidate target and flag it if not word aligned.
   always_comb begin
      next_pc = pc + INSTR_BYTES;
      case (pc_source)
         PC_JALR:   next_pc = jalr_target & ~32'h0000_0001;
         PC_BRANCH: next_pc = branch_target;
         PC_JAL:    next_pc = jal_target;
         default:   next_pc = pc + INSTR_BYTES;
      endcase
      misaligned = (next_pc[1:0] != 2'b00);
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and single-outstanding instruction fetcher.
// Optional commit/redirect statistics counters: define BRANCH_STATS_EN.
//
// state | meaning
// FETCH | imem_req high with imem_addr=pc until accepted
// WAIT  | request accepted, waiting for imem_rvalid
// HOLD  | ir/pc valid for decode, waiting for pc_write
module pc_fetch_ctrl
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [2:0]  pc_source,
   input  logic [31:0] jalr_target,
   input  logic [31:0] branch_target,
   input  logic [31:0] jal_target,
   input  logic        pc_write,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic [31:0] pc,
   output logic        misalign_err,
   output logic [31:0] bad_addr
`ifdef BRANCH_STATS_EN
  ,output logic [31:0] commit_cnt,
   output logic [31:0] redirect_cnt
`endif
);

   fetch_state_t state_q;
   logic [31:0]  pc_q;
   logic [31:0]  ir_q;
   logic         ir_valid_q;
   logic         req_q;
   logic         misalign_q;
   logic [31:0]  bad_addr_q;
   logic [31:0]  next_pc_d;
   logic         next_mis_d;

   pc_next_mux u_next (
      .pc            (pc_q),
      .pc_source     (pc_source),
      .jalr_target   (jalr_target),
      .branch_target (branch_target),
      .jal_target    (jal_target),
      .next_pc       (next_pc_d),
      .misaligned    (next_mis_d)
   );

   // Fetch FSM; req is registered so it first rises one edge after reset release.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= FETCH;
         pc_q       <= RESET_VEC;
         ir_q       <= 32'h0;
         ir_valid_q <= 1'b0;
         req_q      <= 1'b0;
         misalign_q <= 1'b0;
         bad_addr_q <= 32'h0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            FETCH: begin
               if (req_q && imem_ready) begin
                  req_q   <= 1'b0;
                  state_q <= WAIT;
               end else begin
                  req_q <= 1'b1;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  ir_q       <= imem_rdata;
                  ir_valid_q <= 1'b1;
                  state_q    <= HOLD;
               end
            end
            HOLD: begin
               if (pc_write) begin
                  if (next_mis_d) begin
                     pc_q       <= TRAP_VEC;
                     bad_addr_q <= next_pc_d;
                     misalign_q <= 1'b1;
                  end else begin
                     pc_q <= next_pc_d;
                  end
                  ir_valid_q <= 1'b0;
                  req_q      <= 1'b1;
                  state_q    <= FETCH;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= FETCH;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] commit_cnt_q;
   logic [31:0] redirect_cnt_q;

   // Saturating counts of accepted commits and of non-sequential selections.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         commit_cnt_q   <= 32'h0;
         redirect_cnt_q <= 32'h0;
      end else if (state_q == HOLD && pc_write) begin
         commit_cnt_q <= sat_inc(commit_cnt_q);
         if (pc_source == PC_JALR || pc_source == PC_BRANCH || pc_source == PC_JAL)
            redirect_cnt_q <= sat_inc(redirect_cnt_q);
      end
   end

   assign commit_cnt   = commit_cnt_q;
   assign redirect_cnt = redirect_cnt_q;
`endif

   assign imem_req     = req_q;
   assign imem_addr    = pc_q;
   assign pc           = pc_q;
   assign ir           = ir_q;
   assign ir_valid     = ir_valid_q;
   assign misalign_err = misalign_q;
   assign bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed test-plan sequence with
// literal expectations, then randomized traffic against a behavioural model.
module tb_pc_fetch_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [2:0]  pc_source = 3'd0;
   logic [31:0] jalr_target = 32'h0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] jal_target = 32'h0;
   logic        pc_write = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] ir;
   logic        ir_valid;
   logic [31:0] pc;
   logic        misalign_err;
   logic [31:0] bad_addr;
`ifdef BRANCH_STATS_EN
   logic [31:0] commit_cnt;
   logic [31:0] redirect_cnt;
`endif

   pc_fetch_ctrl #(.RESET_VEC(32'h0000_0000), .TRAP_VEC(32'h0000_0100)) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .pc_source     (pc_source),
      .jalr_target   (jalr_target),
      .branch_target (branch_target),
      .jal_target    (jal_target),
      .pc_write      (pc_write),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .ir            (ir),
      .ir_valid      (ir_valid),
      .pc            (pc),
      .misalign_err  (misalign_err),
      .bad_addr      (bad_addr)
`ifdef BRANCH_STATS_EN
     ,.commit_cnt    (commit_cnt),
      .redirect_cnt  (redirect_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int passed = 0;

   // Behavioural model: where the fetch transaction stands (0 requesting,
   // 1 awaiting data, 2 instruction held) plus the architecturally visible values.
   int          m_phase;
   bit          m_started;
   logic [31:0] m_pc, m_ir, m_bad, m_cc, m_rc;
   bit          m_irv, m_mis;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      m_phase = 0; m_started = 0;
      m_pc = 32'h0; m_ir = 32'h0; m_bad = 32'h0; m_cc = 32'h0; m_rc = 32'h0;
      m_irv = 0; m_mis = 0;
   endtask

   function automatic logic [31:0] sat1(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic compare_all();
      chk("imem_req", {31'h0, imem_req}, {31'h0, (m_phase == 0) && m_started});
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("ir_valid", {31'h0, ir_valid}, {31'h0, m_irv});
      chk("ir", ir, m_ir);
      chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_mis});
      chk("bad_addr", bad_addr, m_bad);
`ifdef BRANCH_STATS_EN
      chk("commit_cnt", commit_cnt, m_cc);
      chk("redirect_cnt", redirect_cnt, m_rc);
`endif
   endtask

   // Entered and left at a falling edge: compare, drive, advance model, clock.
   task automatic step(input bit rdy, input bit rv, input logic [31:0] rd,
                       input bit pw, input logic [2:0] src,
                       input logic [31:0] jr, input logic [31:0] br, input logic [31:0] jl);
      logic [31:0] tgt;
      bit req_now;
      compare_all();
      imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
      pc_write = pw; pc_source = src;
      jalr_target = jr; branch_target = br; jal_target = jl;
      req_now = (m_phase == 0) && m_started;
      m_mis = 0;
      if (m_phase == 0) begin
         if (req_now && rdy) m_phase = 1;
      end else if (m_phase == 1) begin
         if (rv) begin m_ir = rd; m_irv = 1; m_phase = 2; end
      end else if (pw) begin
         case (src)
            3'd1:    tgt = {jr[31:1], 1'b0};
            3'd2:    tgt = br;
            3'd3:    tgt = jl;
            default: tgt = m_pc + 32'd4;
         endcase
         m_cc = sat1(m_cc);
         if (src >= 3'd1 && src <= 3'd3) m_rc = sat1(m_rc);
         if (tgt[1:0] != 2'b00) begin
            m_pc = 32'h0000_0100; m_bad = tgt; m_mis = 1;
         end else begin
            m_pc = tgt;
         end
         m_irv = 0;
         m_phase = 0;
      end
      m_started = 1;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle(input bit rdy);
      step(rdy, 0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic commit(input logic [2:0] src, input logic [31:0] jr,
                         input logic [31:0] br, input logic [31:0] jl);
      step(0, 0, 32'h0, 1, src, jr, br, jl);
   endtask

   task automatic fetch_done(input logic [31:0] rd);
      idle(1);
      step(0, 1, rd, 0, 3'd0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] t0, t1, t2;
      model_reset();
      repeat (2) @(negedge CLK);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
      chk("rst_bad_addr", bad_addr, 32'h0);
      RST_N = 1'b1;

      // First fetch: accept immediately, data two cycles after accept.
      idle(1);
      chk("first_req", {31'h0, imem_req}, 32'h1);
      chk("first_addr", imem_addr, 32'h0);
      idle(1);
      idle(0);
      step(0, 1, 32'h0000_0013, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      chk("hold_ir", ir, 32'h0000_0013);
      chk("hold_ir_valid", {31'h0, ir_valid}, 32'h1);
      chk("hold_pc", pc, 32'h0);

      commit(3'd0, 32'h0, 32'h0, 32'h0);
      chk("plus4_req", {31'h0, imem_req}, 32'h1);
      chk("plus4_addr", imem_addr, 32'h4);
      fetch_done(32'h0000_0093);

      commit(3'd2, 32'h0, 32'h0000_0040, 32'h0);
      chk("branch_addr", imem_addr, 32'h40);
      fetch_done(32'h0000_0113);

      commit(3'd3, 32'h0, 32'h0, 32'h0000_0042);
      chk("mis_pulse", {31'h0, misalign_err}, 32'h1);
      chk("mis_bad_addr", bad_addr, 32'h42);
      chk("mis_trap_addr", imem_addr, 32'h100);
`ifdef BRANCH_STATS_EN
      chk("stats_commit", commit_cnt, 32'd3);
      chk("stats_redirect", redirect_cnt, 32'd2);
`endif
      // Ready held low for three cycles while pc_write is pulsed.
      step(0, 0, 32'h0, 1, 3'd2, 32'h0, 32'h0000_0500, 32'h0);
      chk("mis_one_cycle", {31'h0, misalign_err}, 32'h0);
      step(0, 0, 32'h0, 1, 3'd2, 32'h0, 32'h0000_0500, 32'h0);
      step(0, 0, 32'h0, 1, 3'd2, 32'h0, 32'h0000_0500, 32'h0);
      chk("stall_req", {31'h0, imem_req}, 32'h1);
      chk("stall_addr", imem_addr, 32'h100);
      step(1, 0, 32'h0, 1, 3'd2, 32'h0, 32'h0000_0500, 32'h0);
      step(0, 0, 32'h0, 1, 3'd2, 32'h0, 32'h0000_0500, 32'h0);
      chk("wait_pc_write_ignored", pc, 32'h100);
      step(0, 1, 32'hDEAD_BEEF, 0, 3'd0, 32'h0, 32'h0, 32'h0);

      commit(3'd2, 32'h0, 32'hFFFF_FFFC, 32'h0);
      fetch_done(32'h0000_0213);
      commit(3'd0, 32'h0, 32'h0, 32'h0);
      chk("wrap_addr", imem_addr, 32'h0);
      fetch_done(32'h0000_0313);
      commit(3'd1, 32'h0000_0081, 32'h0, 32'h0);
      chk("jalr_addr", imem_addr, 32'h80);
      chk("jalr_no_err", {31'h0, misalign_err}, 32'h0);
      idle(1);

      // Reset while waiting for read data.
      RST_N = 1'b0;
      #1;
      chk("midrst_pc", pc, 32'h0);
      chk("midrst_ir_valid", {31'h0, ir_valid}, 32'h0);
      chk("midrst_req", {31'h0, imem_req}, 32'h0);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;

      // Randomized traffic, including spurious rvalid and pc_write outside HOLD.
      for (int i = 0; i < 3000; i++) begin
         t0 = $urandom; t1 = $urandom; t2 = $urandom;
         if ($urandom_range(0, 99) < 75) t1[1:0] = 2'b00;
         if ($urandom_range(0, 99) < 75) t2[1:0] = 2'b00;
         if ($urandom_range(0, 99) < 50) t0[1] = 1'b0;
         if ($urandom_range(0, 99) < 5)  t1 = 32'hFFFF_FFFC;
         step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40, $urandom,
              $urandom_range(0, 99) < 35, 3'($urandom_range(0, 7)), t0, t1, t2);
      end
      compare_all();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
